// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller
//   Shares the instruction memory's single address port between the boot-time
//   program loader and the core fetch path. BOOT accepts loader word writes;
//   boot_done switches to RUN, which steps a PC and captures one instruction
//   per cycle into a valid/ready output register, with branch redirects.
//   Any illegal fetch or redirect address parks the block in FAULT until reset.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   load_valid/addr/data        loader write request (word, byte address)
//   load_ready                  write accepted this cycle (high in BOOT)
//   load_err                    one-cycle registered pulse on a rejected write
//   boot_done                   pulse that ends loading
//   imem_addr/we/wdata          memory port (address, word write enable, data)
//   imem_rdata                  combinational read word at imem_addr
//   redirect_valid/pc           branch/jump redirect
//   instr_valid/ready/instr/pc  output instruction register toward decode
//   running, fault              state is RUN / state is FAULT
module imem_fetch_controller #(
    parameter int unsigned MEM_BYTES = 32,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        load_err,
    input  logic        boot_done,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        running,
    output logic        fault
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        load_err_q, load_err_d;
    logic        load_req;

    // Word aligned and inside the array; full 32-bit unsigned compare so that
    // wrapped or huge addresses are rejected rather than aliased.
    function automatic logic is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST_WORD);
    endfunction

    // Qualified by reset so no write can slip into memory while reset is held.
    assign load_req = load_valid && !reset;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        load_err_d    = 1'b0;
        load_ready    = 1'b0;
        imem_we       = 1'b0;
        imem_addr     = pc_q;
        imem_wdata    = load_data;

        unique case (state_q)
            ST_BOOT: begin
                load_ready = 1'b1;
                if (load_req) begin
                    if (is_legal(load_addr)) begin
                        imem_we   = 1'b1;
                        imem_addr = load_addr;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
                if (boot_done) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    // Flush wins over a simultaneous consume; no capture.
                    instr_valid_d = 1'b0;
                    if (is_legal(redirect_pc)) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else if (!instr_valid_q || instr_ready) begin
                    if (is_legal(pc_q)) begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                    end else begin
                        // Sequential run-off past the end of memory.
                        instr_valid_d = 1'b0;
                        state_d       = ST_FAULT;
                    end
                end
            end

            ST_FAULT: begin
                instr_valid_d = 1'b0;
            end

            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            load_err_q    <= load_err_d;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign load_err    = load_err_q;
    assign running     = (state_q == ST_RUN);
    assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller with MEM_BYTES=32, RESET_PC=0.
// Expected instructions come from a bench-side word model filled as loads are
// issued; expected fetch results are queued when the stimulus that causes them
// is driven and compared as the DUT presents them.
module tb_imem_fetch_controller;

    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_err;
    logic        boot_done;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        running;
    logic        fault;

    imem_fetch_controller #(
        .MEM_BYTES(32),
        .RESET_PC (RPC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .load_err      (load_err),
        .boot_done     (boot_done),
        .imem_addr     (imem_addr),
        .imem_we       (imem_we),
        .imem_wdata    (imem_wdata),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .running       (running),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Instruction memory: word writes, combinational read.
    logic [31:0] mem_w [0:7];
    always @(posedge clk) if (imem_we) mem_w[imem_addr[4:2]] <= imem_wdata;
    always_comb begin
        imem_rdata = 32'h0;
        if (imem_addr <= 32'd28) imem_rdata = mem_w[imem_addr[4:2]];
    end

    logic [31:0] model [0:7];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = model[pc[4:2]];
        sb.push_back(e);
    endtask

    task automatic sb_pop();
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic sb_check(input string tag);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed output with empty scoreboard, expected an entry", tag);
        end else begin
            check({tag, "_valid"}, instr_valid, 1);
            check({tag, "_pc"}, instr_pc, sb[0].pc);
            check({tag, "_instr"}, instr, sb[0].word);
        end
    endtask

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= 32'd28);
    endfunction

    // Called at edge+1; drives one write for one cycle.
    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        logic lg;
        lg = legal(a);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        #1;
        check("load_ready", load_ready, 1);
        check("load_we", imem_we, lg);
        if (lg) begin
            check("load_waddr", imem_addr, a);
            check("load_wdata", imem_wdata, d);
            model[a[4:2]] = d;
        end
        tick();
        load_valid = 1'b0;
        check("load_err", load_err, !lg);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_instr"}, instr, 0);
        check({tag, "_ipc"}, instr_pc, 0);
        check({tag, "_lerr"}, load_err, 0);
        check({tag, "_run"}, running, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_lready"}, load_ready, 1);
        check({tag, "_we"}, imem_we, 0);
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_addr = 32'h0; load_data = 32'h0;
        boot_done = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;

        // A legal write request during reset must not reach memory.
        #2;
        load_valid = 1'b1; load_addr = 32'h4; load_data = 32'hdeadbeef;
        #1;
        check_reset_outputs("rst");
        load_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Program load, then two rejected writes (misaligned, past end).
        load_word(32'h00, 32'h00940333);
        load_word(32'h04, 32'h413903b3);
        load_word(32'h08, 32'h035a02b3);
        for (int i = 3; i < 8; i++) load_word(32'(i * 4), 32'ha5000000 + 32'(i));
        load_word(32'h1e, 32'h11111111);
        load_word(32'h20, 32'h22222222);
        tick();
        check("lerr_pulse_end", load_err, 0);

        // Boot and stream three instructions; first valid two cycles later.
        boot_done = 1'b1; instr_ready = 1'b1;
        push(32'h0); push(32'h4); push(32'h8);
        tick();
        boot_done = 1'b0;
        check("boot_run", running, 1);
        check("boot_bubble", instr_valid, 0);
        check("boot_addr", imem_addr, RPC);
        check("boot_lready", load_ready, 0);
        tick(); sb_check("f0"); sb_pop();
        tick(); sb_check("f4");

        // Stall on pc=4 for three cycles.
        instr_ready = 1'b0;
        repeat (3) begin
            tick();
            sb_check("hold4");
            check("hold_addr", imem_addr, 32'h8);
        end
        instr_ready = 1'b1; sb_pop();
        tick(); sb_check("f8");

        // Redirect while consuming pc=8: flush, bubble, target next.
        redirect_valid = 1'b1; redirect_pc = 32'h4; sb.delete(); push(32'h4);
        tick();
        redirect_valid = 1'b0;
        check("redir_bubble", instr_valid, 0);
        check("redir_addr", imem_addr, 32'h4);
        tick(); sb_check("r4");

        // Redirect to 0x10 while pc=4 is held and stalled.
        instr_ready = 1'b0;
        tick(); sb_check("r4_hold");
        redirect_valid = 1'b1; redirect_pc = 32'h10; sb.delete();
        push(32'h10); push(32'h14); push(32'h18); push(32'h1c);
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        check("redir2_bubble", instr_valid, 0);
        check("redir2_addr", imem_addr, 32'h10);
        tick(); sb_check("r10"); sb_pop();
        tick(); sb_check("s14"); sb_pop();
        tick(); sb_check("s18"); sb_pop();
        tick(); sb_check("s1c"); sb_pop();

        // Running off the end faults.
        tick();
        check("runoff_fault", fault, 1);
        check("runoff_valid", instr_valid, 0);
        check("runoff_running", running, 0);

        // FAULT ignores loads, boot_done and redirects.
        load_valid = 1'b1; load_addr = 32'h0; load_data = 32'hffffffff;
        boot_done = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0;
        #1;
        check("flt_we", imem_we, 0);
        check("flt_lready", load_ready, 0);
        tick();
        load_valid = 1'b0; boot_done = 1'b0; redirect_valid = 1'b0;
        check("flt_sticky", fault, 1);
        check("flt_lerr", load_err, 0);
        check("flt_valid", instr_valid, 0);

        // Reset out of FAULT, boot, then an illegal redirect target.
        reset = 1'b1;
        #1;
        check("flt_rst_async", fault, 0);
        tick();
        reset = 1'b0;
        boot_done = 1'b1; instr_ready = 1'b1; sb.delete(); push(32'h0);
        tick();
        boot_done = 1'b0;
        tick(); sb_check("b2_f0"); sb_pop();
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0;
        check("badredir_fault", fault, 1);
        check("badredir_valid", instr_valid, 0);

        // Reset mid-RUN, then reboot from preserved memory.
        reset = 1'b1;
        tick();
        reset = 1'b0; boot_done = 1'b1;
        tick();
        boot_done = 1'b0;
        tick();
        tick();
        check("mid_run", running, 1);
        check("mid_valid", instr_valid, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        reset = 1'b0;
        sb.delete(); push(32'h0); push(32'h4);
        boot_done = 1'b1;
        tick();
        boot_done = 1'b0;
        tick(); sb_check("rb_f0"); sb_pop();
        tick(); sb_check("rb_f4"); sb_pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
